// File: rtl/nrad_share_ctrl.sv
// nrad_share_ctrl: round-robin sequencer that time-shares one external
// combinational 4b/2b non-restoring divider between two valid/ready requesters.
module nrad_share_ctrl #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_x,
    input  logic [1:0] req0_y,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_x,
    input  logic [1:0] req1_y,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [2:0] rsp0_q,
    output logic [2:0] rsp0_r,
    output logic       rsp0_err,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    output logic [2:0] rsp1_q,
    output logic [2:0] rsp1_r,
    output logic       rsp1_err,
    input  logic       rsp1_ready,
    output logic [3:0] div_x,
    output logic [1:0] div_y,
    input  logic [2:0] div_q,
    input  logic [2:0] div_r,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0]      div_x_q, div_x_d;
    logic [1:0]      div_y_q, div_y_d;
    logic [1:0][2:0] q_q, q_d;
    logic [1:0][2:0] r_q, r_d;
    logic [1:0]      err_q, err_d;

    logic       grant0, grant1;
    logic       accept, acc_id, acc_err, rsp_take;
    logic [3:0] acc_x;
    logic [1:0] acc_y;

    // prio names the requester that wins when both are valid.
    assign grant0     = req0_valid & (~req1_valid | ~prio_q);
    assign grant1     = req1_valid & (~req0_valid | prio_q);
    assign req0_ready = rst_n & (state_q == IDLE) & grant0;
    assign req1_ready = rst_n & (state_q == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign acc_id     = grant1;
    assign acc_x      = acc_id ? req1_x : req0_x;
    assign acc_y      = acc_id ? req1_y : req0_y;
    // Dividing by one with x >= 8 yields a quotient that needs four bits.
    assign acc_err    = (acc_y == 2'd0) | ((acc_y == 2'd1) & acc_x[3]);
    assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        div_x_d = div_x_q;
        div_y_d = div_y_q;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = acc_id;
                    if (acc_err) begin
                        q_d[acc_id]   = 3'b111;
                        r_d[acc_id]   = 3'b000;
                        err_d[acc_id] = 1'b1;
                        state_d       = RESP;
                    end else begin
                        div_x_d = acc_x;
                        div_y_d = acc_y;
                        cnt_d   = CNT_INIT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    q_d[owner_q]   = div_q;
                    r_d[owner_q]   = div_r;
                    err_d[owner_q] = 1'b0;
                    state_d        = RESP;
                end
            end
            RESP: begin
                if (rsp_take) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 2'd0;
            div_x_q <= 4'd0;
            div_y_q <= 2'd0;
            // NOTE: result registers are reset because they drive outputs whose reset value is defined.
            q_q     <= '0;
            r_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            div_x_q <= div_x_d;
            div_y_q <= div_y_d;
            q_q     <= q_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp0_q     = q_q[0];
    assign rsp0_r     = r_q[0];
    assign rsp0_err   = err_q[0];
    assign rsp1_q     = q_q[1];
    assign rsp1_r     = r_q[1];
    assign rsp1_err   = err_q[1];
    assign div_x      = div_x_q;
    assign div_y      = div_y_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_nrad_share_ctrl.sv
// Bench for nrad_share_ctrl: one environment per LAT value 1..4, each with a
// settle-aware divider model, a transaction-level reference and directed plus random stimulus.
module tb_nrad_share_ctrl;

    int n_cmp  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_env
        localparam int L = gi + 1;

        logic       rst_n = 1'b0;
        logic [1:0] req_valid = 2'b00;
        logic [1:0] rsp_ready = 2'b11;
        logic [3:0] req_x [2];
        logic [1:0] req_y [2];
        logic [1:0] req_ready, rsp_valid, rsp_err;
        logic [2:0] rsp_q [2];
        logic [2:0] rsp_r [2];
        logic [3:0] div_x;
        logic [1:0] div_y;
        logic [2:0] div_q, div_r;
        logic       busy;
        bit         done = 1'b0;

        nrad_share_ctrl #(.LAT(L)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (req_valid[0]),
            .req0_x     (req_x[0]),
            .req0_y     (req_y[0]),
            .req0_ready (req_ready[0]),
            .req1_valid (req_valid[1]),
            .req1_x     (req_x[1]),
            .req1_y     (req_y[1]),
            .req1_ready (req_ready[1]),
            .rsp0_valid (rsp_valid[0]),
            .rsp0_q     (rsp_q[0]),
            .rsp0_r     (rsp_r[0]),
            .rsp0_err   (rsp_err[0]),
            .rsp0_ready (rsp_ready[0]),
            .rsp1_valid (rsp_valid[1]),
            .rsp1_q     (rsp_q[1]),
            .rsp1_r     (rsp_r[1]),
            .rsp1_err   (rsp_err[1]),
            .rsp1_ready (rsp_ready[1]),
            .div_x      (div_x),
            .div_y      (div_y),
            .div_q      (div_q),
            .div_r      (div_r),
            .busy       (busy)
        );

        function automatic string nm(input string s);
            return $sformatf("L%0d %s", L, s);
        endfunction

        // Divider model: answers are only trustworthy once operands have been stable for LAT cycles.
        int         stable   = 0;
        logic [5:0] prev_ops = '0;
        int         dq, dr;
        initial forever begin
            @(negedge clk);
            if ({div_x, div_y} == prev_ops) stable = stable + 1;
            else stable = 0;
            prev_ops = {div_x, div_y};
        end
        always_comb begin
            dq = 7;
            dr = 0;
            if (div_y != 2'd0) begin
                dq = int'(div_x) / int'(div_y);
                dr = int'(div_x) % int'(div_y);
            end
            div_q = 3'(dq);
            div_r = 3'(dr);
            if (stable < L - 1) begin
                div_q = ~3'(dq);
                div_r = ~3'(dr);
            end
        end

        // Transaction-level reference, compared every cycle.
        initial begin : cmp
            bit         m_busy, m_prio, m_owner, m_err;
            int         m_x, m_y, m_q, m_r, m_wait, m_edges;
            logic [1:0] exp_ready, exp_valid;
            m_busy = 1'b0;
            m_prio = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    m_busy = 1'b0;
                    m_prio = 1'b0;
                    check(nm("reset ready"), int'(req_ready), 0);
                    check(nm("reset rsp_valid"), int'(rsp_valid), 0);
                    check(nm("reset busy"), int'(busy), 0);
                    check(nm("reset div"), int'({div_x, div_y}), 0);
                    check(nm("reset rsp data"),
                          int'({rsp_q[0], rsp_r[0], rsp_q[1], rsp_r[1], rsp_err}), 0);
                end else if (!m_busy) begin
                    exp_ready = req_valid;
                    if (req_valid == 2'b11) exp_ready = m_prio ? 2'b10 : 2'b01;
                    check(nm("idle ready"), int'(req_ready), int'(exp_ready));
                    check(nm("idle busy"), int'(busy), 0);
                    check(nm("idle rsp_valid"), int'(rsp_valid), 0);
                    if (exp_ready != 2'b00) begin
                        m_owner = exp_ready[1];
                        m_x     = int'(req_x[m_owner]);
                        m_y     = int'(req_y[m_owner]);
                        m_err   = (m_y == 0) || (m_y == 1 && m_x >= 8);
                        if (m_err) begin
                            m_q = 7; m_r = 0; m_wait = 1;
                        end else begin
                            m_q = m_x / m_y; m_r = m_x % m_y; m_wait = L + 1;
                        end
                        m_edges = 0;
                        m_busy  = 1'b1;
                    end
                end else begin
                    check(nm("busy ready"), int'(req_ready), 0);
                    check(nm("busy flag"), int'(busy), 1);
                    exp_valid = (m_edges >= m_wait) ? (2'b01 << m_owner) : 2'b00;
                    check(nm("rsp_valid"), int'(rsp_valid), int'(exp_valid));
                    if (exp_valid != 2'b00) begin
                        check(nm("rsp q"), int'(rsp_q[m_owner]), m_q);
                        check(nm("rsp r"), int'(rsp_r[m_owner]), m_r);
                        check(nm("rsp err"), int'(rsp_err[m_owner]), int'(m_err));
                    end
                    if (!m_err) check(nm("div operands"), int'({div_x, div_y}), m_x * 4 + m_y);
                    if (exp_valid != 2'b00 && rsp_ready[m_owner]) begin
                        m_busy = 1'b0;
                        m_prio = ~m_owner;
                    end
                end
                if (m_busy) m_edges++;
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic present(input int id, input int x, input int y, output int w);
            req_x[id]     = 4'(x);
            req_y[id]     = 2'(y);
            req_valid[id] = 1'b1;
            w = -1;
            for (int i = 0; i < 30 && w < 0; i++) begin
                @(negedge clk);
                if (req_ready[id]) w = i;
                step();
            end
            req_valid[id] = 1'b0;
        endtask

        task automatic run_op(input int id, input int x, input int y,
                              output int q, output int r, output int e,
                              output int lat, output int w);
            present(id, x, y, w);
            lat = -1; q = -1; r = -1; e = -1;
            for (int i = 1; i < 30 && lat < 0 && w >= 0; i++) begin
                @(negedge clk);
                if (rsp_valid[id]) begin
                    lat = i;
                    q   = int'(rsp_q[id]);
                    r   = int'(rsp_r[id]);
                    e   = int'(rsp_err[id]);
                end
                step();
            end
        endtask

        task automatic wait_idle();
            bit idle;
            idle = 1'b0;
            for (int i = 0; i < 40 && !idle; i++) begin
                @(negedge clk);
                idle = !busy;
                step();
            end
            check(nm("wait idle"), int'(idle), 1);
        endtask

        initial begin : drv
            int q, r, e, lat, w, n, seen;
            int ow [3];
            int oq [3];
            int orr [3];
            bit [1:0] xf;
            req_x[0] = '0; req_y[0] = '0; req_x[1] = '0; req_y[1] = '0;
            req_valid = 2'b01;
            repeat (3) step();
            rst_n     = 1'b1;
            req_valid = 2'b00;
            step();

            run_op(0, 13, 3, q, r, e, lat, w);
            check(nm("first accept wait"), w, 0);
            check(nm("13/3 q"), q, 4);
            check(nm("13/3 r"), r, 1);
            check(nm("13/3 err"), e, 0);
            check(nm("13/3 latency"), lat, L + 1);

            run_op(1, 5, 0, q, r, e, lat, w);
            check(nm("5/0 q"), q, 7);
            check(nm("5/0 r"), r, 0);
            check(nm("5/0 err"), e, 1);
            check(nm("5/0 latency"), lat, 1);
            run_op(0, 9, 1, q, r, e, lat, w);
            check(nm("9/1 err"), e, 1);
            check(nm("9/1 latency"), lat, 1);
            run_op(1, 7, 1, q, r, e, lat, w);
            check(nm("7/1 q"), q, 7);
            check(nm("7/1 r"), r, 0);
            check(nm("7/1 err"), e, 0);

            // Contention: both held valid, responses must alternate starting with req0.
            req_x[0] = 4'd14; req_y[0] = 2'd3; req_x[1] = 4'd7; req_y[1] = 2'd2;
            req_valid = 2'b11;
            n = 0;
            for (int i = 0; i < 60 && n < 3; i++) begin
                @(negedge clk);
                if (rsp_valid != 2'b00) begin
                    ow[n]  = int'(rsp_valid[1]);
                    oq[n]  = int'(rsp_valid[1] ? rsp_q[1] : rsp_q[0]);
                    orr[n] = int'(rsp_valid[1] ? rsp_r[1] : rsp_r[0]);
                    n++;
                end
                step();
            end
            req_valid = 2'b00;
            check(nm("contention count"), n, 3);
            for (int i = 0; i < n; i++) begin
                check(nm("contention owner"), ow[i], i % 2);
                check(nm("contention q"), oq[i], (i % 2 == 0) ? 4 : 3);
                check(nm("contention r"), orr[i], (i % 2 == 0) ? 2 : 1);
            end
            wait_idle();

            // Backpressure on rsp0 while req1 waits.
            rsp_ready = 2'b00;
            present(0, 11, 2, w);
            req_x[1] = 4'd5; req_y[1] = 2'd2; req_valid[1] = 1'b1;
            lat = -1;
            for (int i = 1; i < 30 && lat < 0; i++) begin
                @(negedge clk);
                if (rsp_valid[0]) lat = i;
                step();
            end
            check(nm("bp latency"), lat, L + 1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check(nm("bp q"), int'(rsp_q[0]), 5);
                check(nm("bp r"), int'(rsp_r[0]), 1);
                check(nm("bp err"), int'(rsp_err[0]), 0);
                check(nm("bp valid"), int'(rsp_valid), 1);
                check(nm("bp ready"), int'(req_ready), 0);
                check(nm("bp busy"), int'(busy), 1);
                step();
            end
            rsp_ready = 2'b11;
            @(negedge clk);
            step();
            @(negedge clk);
            check(nm("bp release busy"), int'(busy), 0);
            check(nm("bp release ready"), int'(req_ready), 2);
            step();
            req_valid[1] = 1'b0;
            wait_idle();

            // Reset during the second CALC cycle (the only one when LAT=1).
            present(0, 13, 3, w);
            repeat ((L >= 2) ? 1 : 0) step();
            rst_n = 1'b0;
            @(negedge clk);
            check(nm("abort busy"), int'(busy), 0);
            check(nm("abort rsp_valid"), int'(rsp_valid), 0);
            check(nm("abort div"), int'({div_x, div_y}), 0);
            step();
            step();
            rst_n = 1'b1;
            seen = 0;
            for (int i = 0; i < L + 6; i++) begin
                @(negedge clk);
                if (rsp_valid != 2'b00) seen = 1;
                step();
            end
            check(nm("no rsp after abort"), seen, 0);

            // Sweep every operand pair, alternating requesters.
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 4; y++) begin
                    bit eerr;
                    eerr = (y == 0) || (y == 1 && x >= 8);
                    run_op((x * 4 + y) % 2, x, y, q, r, e, lat, w);
                    check(nm("sweep q"), q, eerr ? 7 : x / y);
                    check(nm("sweep r"), r, eerr ? 0 : x % y);
                    check(nm("sweep err"), e, int'(eerr));
                    check(nm("sweep latency"), lat, eerr ? 1 : L + 1);
                end
            end

            // Random traffic; requests are held stable until they transfer.
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                xf = req_valid & req_ready;
                step();
                for (int k = 0; k < 2; k++) begin
                    if (!req_valid[k] || xf[k]) begin
                        req_valid[k] = 1'($urandom_range(0, 1));
                        req_x[k]     = 4'($urandom);
                        req_y[k]     = 2'($urandom);
                    end
                end
                rsp_ready = 2'($urandom);
            end
            @(negedge clk);
            xf = req_valid & req_ready;
            step();
            req_valid = req_valid & ~xf;
            rsp_ready = 2'b11;
            for (int i = 0; i < 40 && req_valid != 2'b00; i++) begin
                @(negedge clk);
                xf = req_valid & req_ready;
                step();
                req_valid = req_valid & ~xf;
            end
            wait_idle();
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 40000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_env[0].done && g_env[1].done && g_env[2].done && g_env[3].done;
        end
        check("all environments finished", int'(all_done), 1);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
